// File: rtl/bp_me_wormhole_packet_decode_mem_cmd_rx_pkg.sv
// Shared types and helpers for the mem-command wormhole receive path:
// packet struct declaration macro, packet size helpers and the rx FSM states.

`ifndef BP_ME_WORMHOLE_PACKET_DECODE_MEM_CMD_RX_PKG_SV
`define BP_ME_WORMHOLE_PACKET_DECODE_MEM_CMD_RX_PKG_SV

// Packet layout, MSB first: {data, msg, src_cid, src_cord, len, cid, cord}; cord lands at bit 0.
`define DECLARE_BP_MEM_WORMHOLE_PACKET_S(cord_w, cid_w, len_w, msg_w, data_w, struct_name) \
  typedef struct packed {                 \
    logic [data_w-1:0] data;              \
    logic [msg_w-1:0]  msg;               \
    logic [cid_w-1:0]  src_cid;           \
    logic [cord_w-1:0] src_cord;          \
    logic [len_w-1:0]  len;               \
    logic [cid_w-1:0]  cid;               \
    logic [cord_w-1:0] cord;              \
  } struct_name

package bp_me_wormhole_packet_decode_mem_cmd_rx_pkg;

  typedef enum logic [1:0] {
    e_rx_idle,
    e_rx_recv,
    e_rx_out
  } bp_me_wormhole_rx_state_e;

  // Total packet width in bits for a given field configuration.
  function automatic int bp_mem_wormhole_pkt_width(input int cord_w, input int cid_w,
                                                   input int len_w, input int msg_w,
                                                   input int data_w);
    return data_w + msg_w + 2 * (cid_w + cord_w) + len_w;
  endfunction

  // Largest len value a packet can carry: number of flits minus one.
  function automatic int bp_mem_wormhole_max_len(input int pkt_w, input int flit_w);
    return (pkt_w + flit_w - 1) / flit_w - 1;
  endfunction

endpackage

`endif

// File: rtl/bp_me_wormhole_flit_sipo.sv
// Serial-in parallel-out flit buffer: writes each accepted flit at the slot
// given by its running counter, drops flits past the last slot, clears on demand.

module bp_me_wormhole_flit_sipo #(
  parameter int flit_width_p = 64,
  parameter int num_flits_p  = 10,
  parameter int cnt_width_p  = 4
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic                                clear_i,
  input  logic                                write_v_i,
  input  logic [flit_width_p-1:0]             flit_i,
  output logic [cnt_width_p-1:0]              cnt_o,
  output logic [num_flits_p*flit_width_p-1:0] data_o
);

  logic [num_flits_p*flit_width_p-1:0] buffer_r;
  logic [cnt_width_p-1:0]              cnt_r;

  // Flit slot writes and counter advance; overflow flits are counted but not stored.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      buffer_r <= '0;
      cnt_r    <= '0;
    end else if (clear_i) begin
      buffer_r <= '0;
      cnt_r    <= '0;
    end else if (write_v_i) begin
      if (int'(cnt_r) < num_flits_p) begin
        buffer_r[int'(cnt_r)*flit_width_p +: flit_width_p] <= flit_i;
      end
      cnt_r <= cnt_r + cnt_width_p'(1);
    end
  end

  assign cnt_o  = cnt_r;
  assign data_o = buffer_r;

endmodule

// File: rtl/bp_me_wormhole_packet_decode_mem_cmd_rx.sv
// Receive end of the memory-command wormhole link. Reassembles one packet into
// a single buffer and presents {data, msg} as a mem_cmd until it is consumed.

module bp_me_wormhole_packet_decode_mem_cmd_rx
  import bp_me_wormhole_packet_decode_mem_cmd_rx_pkg::*;
#(
  parameter int flit_width_p    = 64,
  parameter int cord_width_p    = 7,
  parameter int cid_width_p     = 2,
  parameter int len_width_p     = 4,
  parameter int msg_hdr_width_p = 72,
  parameter int data_width_p    = 512
) (
  input  logic                                    clk_i,
  input  logic                                    reset_n_i,
  input  logic [flit_width_p-1:0]                 flit_i,
  input  logic                                    flit_v_i,
  output logic                                    flit_ready_o,
  output logic [msg_hdr_width_p+data_width_p-1:0] mem_cmd_o,
  output logic [cord_width_p-1:0]                 src_cord_o,
  output logic [cid_width_p-1:0]                  src_cid_o,
  output logic                                    mem_cmd_v_o,
  input  logic                                    mem_cmd_ready_i,
  output logic                                    len_err_o
);

  localparam int pkt_w_lp = bp_mem_wormhole_pkt_width(cord_width_p, cid_width_p, len_width_p,
                                                      msg_hdr_width_p, data_width_p);
  localparam int max_len_lp = bp_mem_wormhole_max_len(pkt_w_lp, flit_width_p);
  localparam int num_flits_lp = max_len_lp + 1;
  localparam int buf_w_lp = num_flits_lp * flit_width_p;
  localparam logic [len_width_p-1:0] max_len_cmp_lp = len_width_p'(max_len_lp);

  `DECLARE_BP_MEM_WORMHOLE_PACKET_S(cord_width_p, cid_width_p, len_width_p, msg_hdr_width_p,
                                    data_width_p, bp_mem_wormhole_packet_s);

  bp_me_wormhole_rx_state_e state_r, state_n;
  logic [len_width_p-1:0]   len_r, len_n;
  logic                     len_err_r, len_err_n;
  logic                     ready_r, ready_n;
  logic [len_width_p-1:0]   cnt;
  logic [buf_w_lp-1:0]      buffer;
  logic [len_width_p-1:0]   hdr_len;
  logic                     flit_xfer;
  logic                     handshake;
  bp_mem_wormhole_packet_s  pkt;
  logic                     unused_bits;

  assign flit_xfer = flit_v_i & ready_r;
  assign handshake = mem_cmd_v_o & mem_cmd_ready_i;
  assign hdr_len   = flit_i[cord_width_p+cid_width_p +: len_width_p];

  bp_me_wormhole_flit_sipo #(
    .flit_width_p (flit_width_p),
    .num_flits_p  (num_flits_lp),
    .cnt_width_p  (len_width_p)
  ) sipo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (handshake),
    .write_v_i (flit_xfer),
    .flit_i    (flit_i),
    .cnt_o     (cnt),
    .data_o    (buffer)
  );

  // State, latched length, error pulse and registered flit ready.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r   <= e_rx_idle;
      len_r     <= '0;
      len_err_r <= 1'b0;
      ready_r   <= 1'b0;
    end else begin
      state_r   <= state_n;
      len_r     <= len_n;
      len_err_r <= len_err_n;
      ready_r   <= ready_n;
    end
  end

  // Next-state logic: header latches len, RECV counts to len, OUT waits for handshake.
  always_comb begin
    state_n   = state_r;
    len_n     = len_r;
    len_err_n = 1'b0;
    case (state_r)
      e_rx_idle: begin
        if (flit_xfer) begin
          len_n     = hdr_len;
          len_err_n = (hdr_len > max_len_cmp_lp);
          state_n   = (hdr_len == '0) ? e_rx_out : e_rx_recv;
        end
      end
      e_rx_recv: begin
        if (flit_xfer && (cnt == len_r)) begin
          state_n = e_rx_out;
        end
      end
      e_rx_out: begin
        if (handshake) begin
          state_n = e_rx_idle;
        end
      end
      default: state_n = e_rx_idle;
    endcase
    ready_n = (state_n != e_rx_out);
  end

  assign pkt          = buffer[pkt_w_lp-1:0];
  assign mem_cmd_o    = {pkt.data, pkt.msg};
  assign src_cord_o   = pkt.src_cord;
  assign src_cid_o    = pkt.src_cid;
  assign mem_cmd_v_o  = (state_r == e_rx_out);
  assign flit_ready_o = ready_r;
  assign len_err_o    = len_err_r;

  assign unused_bits = ^{buffer[buf_w_lp-1:pkt_w_lp], pkt.len, pkt.cid, pkt.cord};

endmodule

// File: tb/tb_bp_me_wormhole_packet_decode_mem_cmd_rx.sv
// Directed-plus-random bench for the mem-command wormhole receiver. Packets are
// built as flat bit vectors from their fields and compared against the decoded command.

module tb_bp_me_wormhole_packet_decode_mem_cmd_rx;

  localparam int FW = 64;
  localparam int NF = 10;

  logic         clk_i = 1'b0;
  logic         reset_n_i;
  logic [63:0]  flit_i;
  logic         flit_v_i;
  logic         flit_ready_o;
  logic [583:0] mem_cmd_o;
  logic [6:0]   src_cord_o;
  logic [1:0]   src_cid_o;
  logic         mem_cmd_v_o;
  logic         mem_cmd_ready_i;
  logic         len_err_o;

  int checks = 0;
  int errors = 0;

  bp_me_wormhole_packet_decode_mem_cmd_rx dut (
    .clk_i           (clk_i),
    .reset_n_i       (reset_n_i),
    .flit_i          (flit_i),
    .flit_v_i        (flit_v_i),
    .flit_ready_o    (flit_ready_o),
    .mem_cmd_o       (mem_cmd_o),
    .src_cord_o      (src_cord_o),
    .src_cid_o       (src_cid_o),
    .mem_cmd_v_o     (mem_cmd_v_o),
    .mem_cmd_ready_i (mem_cmd_ready_i),
    .len_err_o       (len_err_o)
  );

  // Free-running 10 ns clock.
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [639:0] randBits();
    logic [639:0] r;
    for (int i = 0; i < 20; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Present one flit and wait (bounded) until it is taken; returns at edge+1.
  task automatic sendFlit(input logic [63:0] f);
    int guard;
    guard    = 0;
    flit_i   = f;
    flit_v_i = 1'b1;
    while (!flit_ready_o && guard < 50) begin
      @(posedge clk_i); #1;
      guard++;
    end
    if (guard >= 50) checkOutput("flit_accept_timeout", 640'd0, 640'd1);
    @(posedge clk_i); #1;
    flit_v_i = 1'b0;
  endtask

  // Send a whole packet, check the decoded command, hold it for 'hold' cycles,
  // then either complete the handshake or abort the packet with a reset.
  task automatic applyStimulus(input logic [511:0] data, input logic [71:0] msg,
                               input logic [6:0] scord, input logic [1:0] scid,
                               input logic [3:0] len, input int hold, input bit reset_in_out);
    logic [605:0] pkt;
    logic [639:0] full, masked, r;
    int n;
    pkt    = {data, msg, scid, scord, len, 2'($urandom), 7'($urandom)};
    r      = randBits();
    full   = {r[33:0], pkt};
    n      = (int'(len) + 1 > NF) ? NF : int'(len) + 1;
    masked = full & ((640'd1 << (n * FW)) - 640'd1);
    for (int i = 0; i <= int'(len); i++) begin
      if (i == int'(len)) checkOutput("v_before_last_flit", {639'd0, mem_cmd_v_o}, 640'd0);
      if (i < NF) sendFlit(full[i*FW +: FW]);
      else sendFlit({$urandom, $urandom});
      if (i == 0) checkOutput("len_err_after_header", {639'd0, len_err_o}, {639'd0, (len > 4'd9)});
      if (i == 1) checkOutput("len_err_one_pulse", {639'd0, len_err_o}, 640'd0);
    end
    checkOutput("v_after_last_flit", {639'd0, mem_cmd_v_o}, 640'd1);
    checkOutput("mem_cmd", {56'd0, mem_cmd_o}, {56'd0, masked[605:22]});
    checkOutput("src_cord", {633'd0, src_cord_o}, {633'd0, masked[19:13]});
    checkOutput("src_cid", {638'd0, src_cid_o}, {638'd0, masked[21:20]});
    checkOutput("ready_low_in_out", {639'd0, flit_ready_o}, 640'd0);
    for (int c = 0; c < hold; c++) begin
      flit_v_i = 1'b1;
      flit_i   = {$urandom, $urandom};
      @(posedge clk_i); #1;
      checkOutput("v_held", {639'd0, mem_cmd_v_o}, 640'd1);
      checkOutput("mem_cmd_stable", {56'd0, mem_cmd_o}, {56'd0, masked[605:22]});
      checkOutput("ready_held_low", {639'd0, flit_ready_o}, 640'd0);
    end
    if (reset_in_out) begin
      flit_v_i  = 1'b0;
      reset_n_i = 1'b0;
      #1;
      checkOutput("v_drops_on_reset", {639'd0, mem_cmd_v_o}, 640'd0);
      @(posedge clk_i); #1;
      reset_n_i = 1'b1;
      @(posedge clk_i); #1;
    end else begin
      mem_cmd_ready_i = 1'b1;
      @(posedge clk_i); #1;
      mem_cmd_ready_i = 1'b0;
      flit_v_i        = 1'b0;
      checkOutput("v_after_handshake", {639'd0, mem_cmd_v_o}, 640'd0);
      checkOutput("ready_after_handshake", {639'd0, flit_ready_o}, 640'd1);
    end
  endtask

  initial begin
    logic [511:0] data;
    logic [639:0] r;
    logic [63:0]  hdr;

    reset_n_i       = 1'b0;
    flit_v_i        = 1'b0;
    flit_i          = '0;
    mem_cmd_ready_i = 1'b0;
    #1;
    checkOutput("reset_v", {639'd0, mem_cmd_v_o}, 640'd0);
    checkOutput("reset_ready", {639'd0, flit_ready_o}, 640'd0);
    checkOutput("reset_len_err", {639'd0, len_err_o}, 640'd0);
    checkOutput("reset_mem_cmd", {56'd0, mem_cmd_o}, 640'd0);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    checkOutput("ready_after_release", {639'd0, flit_ready_o}, 640'd1);

    $display("[TB] read len=1");
    applyStimulus(512'd0, 72'hA5A5_A5A5_A5A5_A5A5_A5, 7'h12, 2'd2, 4'd1, 0, 1'b0);

    $display("[TB] 64B write len=9");
    for (int b = 0; b < 64; b++) data[b*8 +: 8] = 8'(b);
    r = randBits();
    applyStimulus(data, r[71:0], 7'h05, 2'd1, 4'd9, 0, 1'b0);

    $display("[TB] back-pressure");
    r = randBits();
    applyStimulus(r[511:0], r[583:512], r[590:584], r[592:591], 4'd3, 5, 1'b0);

    $display("[TB] len=0 single flit");
    r = randBits();
    applyStimulus(r[511:0], r[583:512], r[590:584], r[592:591], 4'd0, 1, 1'b0);

    $display("[TB] len=12 overlength");
    r = randBits();
    applyStimulus(r[511:0], r[583:512], r[590:584], r[592:591], 4'd12, 0, 1'b0);

    $display("[TB] random packets");
    for (int p = 0; p < 8; p++) begin
      r = randBits();
      applyStimulus(r[511:0], r[583:512], r[590:584], r[592:591],
                    4'($urandom_range(0, 12)), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("[TB] reset mid-packet");
    r   = randBits();
    hdr = r[63:0];
    hdr[12:9] = 4'd9;
    sendFlit(hdr);
    sendFlit(r[127:64]);
    sendFlit(r[191:128]);
    reset_n_i = 1'b0;
    #1;
    checkOutput("mid_reset_v", {639'd0, mem_cmd_v_o}, 640'd0);
    checkOutput("mid_reset_ready", {639'd0, flit_ready_o}, 640'd0);
    @(posedge clk_i); #1;
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;
    r = randBits();
    applyStimulus(512'd0, r[71:0], r[78:72], r[80:79], 4'd1, 0, 1'b0);

    $display("[TB] reset while command pending");
    r = randBits();
    applyStimulus(r[511:0], r[583:512], r[590:584], r[592:591], 4'd2, 1, 1'b1);
    r = randBits();
    applyStimulus(r[511:0], r[583:512], r[590:584], r[592:591], 4'd4, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
